// File: rtl/ov7670_line_capture_if.sv
// Signal bundle of the OV7670 line capture stage: camera byte stream in, frame-RAM write port
// and Ethernet-sender handshake out.
interface ov7670_line_capture_if;
  logic        vsync;
  logic        href;
  logic [7:0]  cam_d;
  logic        tx_busy;
  logic        wr_en;
  logic [10:0] addr;
  logic [7:0]  din;
  logic        start;
  logic [9:0]  line_num;
  logic [7:0]  drop_cnt;

  modport master (
    input  vsync, href, cam_d, tx_busy,
    output wr_en, addr, din, start, line_num, drop_cnt
  );

  modport slave (
    output vsync, href, cam_d, tx_busy,
    input  wr_en, addr, din, start, line_num, drop_cnt
  );
endinterface

// File: rtl/ov7670_line_capture.sv
// Captures one OV7670 video line into the Ethernet frame RAM behind a 4-byte line header and
// pulses start; lines arriving while the sender is busy are dropped and counted.
module ov7670_line_capture #(
  parameter int LINE_BYTES = 1280,
  parameter int HDR_BYTES  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ov7670_line_capture_if.master bus
);
  localparam logic [10:0] LINE_LEN = 11'(LINE_BYTES);
  localparam logic [10:0] HDR_LEN  = 11'(HDR_BYTES);

  typedef enum logic [2:0] {
    WAIT_FRAME,
    WAIT_LINE,
    CAPTURE,
    HEADER,
    DONE,
    SKIP
  } state_t;

  state_t      state;
  logic        vsync_s1;
  logic        vsync_prev;
  logic        href_s1;
  logic [7:0]  d_s1;
  logic [10:0] idx;
  logic [9:0]  line_cnt;
  logic [7:0]  frame_cnt;
  logic        long_flag;
  logic [1:0]  hdr_idx;
  logic        wr_en_reg;
  logic [10:0] addr_reg;
  logic [7:0]  din_reg;
  logic        start_reg;
  logic [9:0]  line_num_reg;
  logic [7:0]  drop_cnt_reg;

  logic        short_flag;
  logic [7:0]  hdr_byte0;
  logic [7:0]  hdr_byte;

  // idx is frozen from the end of CAPTURE through HEADER, so the short flag can stay combinational.
  assign short_flag = (idx < LINE_LEN);
  assign hdr_byte0  = {4'b0000, short_flag, long_flag, line_cnt[9:8]};

  always_comb begin
    hdr_byte = hdr_byte0;
    case (hdr_idx)
      2'd1:    hdr_byte = line_cnt[7:0];
      2'd2:    hdr_byte = frame_cnt;
      2'd3:    hdr_byte = idx[7:0];
      default: hdr_byte = hdr_byte0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= WAIT_FRAME;
      vsync_s1     <= 1'b0;
      vsync_prev   <= 1'b0;
      href_s1      <= 1'b0;
      d_s1         <= 8'd0;
      idx          <= 11'd0;
      line_cnt     <= 10'd0;
      frame_cnt    <= 8'd0;
      long_flag    <= 1'b0;
      hdr_idx      <= 2'd0;
      wr_en_reg    <= 1'b0;
      addr_reg     <= 11'd0;
      din_reg      <= 8'd0;
      start_reg    <= 1'b0;
      line_num_reg <= 10'd0;
      drop_cnt_reg <= 8'd0;
    end else begin
      vsync_s1   <= bus.vsync;
      vsync_prev <= vsync_s1;
      href_s1    <= bus.href;
      d_s1       <= bus.cam_d;
      wr_en_reg  <= 1'b0;
      start_reg  <= 1'b0;

      case (state)
        WAIT_FRAME: begin
          if (vsync_prev && !vsync_s1) begin
            line_cnt  <= 10'd0;
            frame_cnt <= frame_cnt + 8'd1;
            state     <= WAIT_LINE;
          end
        end

        // Level-triggered on href so a line that began during DONE is still caught, minus its head.
        WAIT_LINE: begin
          if (vsync_s1) begin
            state <= WAIT_FRAME;
          end else if (href_s1) begin
            if (!bus.tx_busy) begin
              wr_en_reg <= 1'b1;
              addr_reg  <= HDR_LEN;
              din_reg   <= d_s1;
              idx       <= 11'd1;
              long_flag <= 1'b0;
              state     <= CAPTURE;
            end else begin
              if (drop_cnt_reg != 8'hFF) begin
                drop_cnt_reg <= drop_cnt_reg + 8'd1;
              end
              line_cnt <= line_cnt + 10'd1;
              state    <= SKIP;
            end
          end
        end

        CAPTURE: begin
          if (vsync_s1) begin
            state <= WAIT_FRAME;
          end else if (href_s1) begin
            if (idx < LINE_LEN) begin
              wr_en_reg <= 1'b1;
              addr_reg  <= HDR_LEN + idx;
              din_reg   <= d_s1;
              idx       <= idx + 11'd1;
            end else begin
              long_flag <= 1'b1;
            end
          end else begin
            // Header byte 0 goes out on the very cycle the line end is seen.
            wr_en_reg <= 1'b1;
            addr_reg  <= 11'd0;
            din_reg   <= hdr_byte0;
            hdr_idx   <= 2'd1;
            state     <= HEADER;
          end
        end

        HEADER: begin
          if (vsync_s1) begin
            state <= WAIT_FRAME;
          end else begin
            wr_en_reg <= 1'b1;
            addr_reg  <= {9'd0, hdr_idx};
            din_reg   <= hdr_byte;
            hdr_idx   <= hdr_idx + 2'd1;
            if (hdr_idx == 2'd3) begin
              state <= DONE;
            end
          end
        end

        DONE: begin
          start_reg    <= 1'b1;
          line_num_reg <= line_cnt;
          line_cnt     <= line_cnt + 10'd1;
          state        <= WAIT_LINE;
        end

        SKIP: begin
          if (vsync_s1) begin
            state <= WAIT_FRAME;
          end else if (!href_s1) begin
            state <= WAIT_LINE;
          end
        end

        default: state <= WAIT_FRAME;
      endcase
    end
  end

  assign bus.wr_en    = wr_en_reg;
  assign bus.addr     = addr_reg;
  assign bus.din      = din_reg;
  assign bus.start    = start_reg;
  assign bus.line_num = line_num_reg;
  assign bus.drop_cnt = drop_cnt_reg;
endmodule

// File: tb/tb_ov7670_line_capture.sv
// Bench for ov7670_line_capture: expected RAM writes and start pulses are queued while camera
// bytes are driven and matched cycle-exactly against the DUT by a monitor process.
module tb_ov7670_line_capture;
  localparam int LINE_BYTES = 1280;
  localparam int HDR_BYTES  = 4;

  typedef struct {
    int          at;
    logic [10:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct {
    int         at;
    logic [9:0] lnum;
  } st_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         max_addr = 0;
  wr_t        wr_q[$];
  st_t        st_q[$];
  logic [9:0] exp_line = '0;
  logic [7:0] exp_frame = '0;
  logic [7:0] exp_drop = '0;

  ov7670_line_capture_if bus ();

  ov7670_line_capture #(
    .LINE_BYTES(LINE_BYTES),
    .HDR_BYTES (HDR_BYTES)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Inputs are driven on the falling edge; outputs are sampled on the same falling edge.
  task automatic monitor();
    wr_t we;
    st_t se;
    forever begin
      @(negedge clk);
      if (bus.wr_en === 1'b1) begin
        checks++;
        if (int'(bus.addr) > max_addr) max_addr = int'(bus.addr);
        if (wr_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: addr=%0d din=0x%02h cycle=%0d, required no write",
                   bus.addr, bus.din, cyc);
        end else begin
          we = wr_q.pop_front();
          if (bus.addr !== we.addr || bus.din !== we.data || cyc != we.at) begin
            errors++;
            $display("FAIL ram_write: got addr=%0d din=0x%02h cycle=%0d, required addr=%0d din=0x%02h cycle=%0d",
                     bus.addr, bus.din, cyc, we.addr, we.data, we.at);
          end
        end
      end
      if (bus.start === 1'b1) begin
        checks++;
        if (bus.wr_en !== 1'b0) begin
          errors++;
          $display("FAIL start_with_write: wr_en=%b during start, required 0", bus.wr_en);
        end
        checks++;
        if (st_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_start: line_num=%0d cycle=%0d, required no start", bus.line_num, cyc);
        end else begin
          se = st_q.pop_front();
          if (bus.line_num !== se.lnum || cyc != se.at) begin
            errors++;
            $display("FAIL start_pulse: got line_num=%0d cycle=%0d, required line_num=%0d cycle=%0d",
                     bus.line_num, cyc, se.lnum, se.at);
          end else begin
            $display("start line_num=%0d cycle=%0d ok", bus.line_num, cyc);
          end
        end
      end
    end
  endtask

  task automatic start_frame();
    @(negedge clk);
    bus.vsync = 1'b1;
    repeat (3) @(negedge clk);
    bus.vsync = 1'b0;
    exp_frame++;
    exp_line = '0;
    repeat (3) @(negedge clk);
  endtask

  // busy_mode: 0 = sender idle, 1 = sender busy at line start (drop), 2 = busy rises mid-line.
  task automatic drive_line(input int n, input int busy_mode, input int seed);
    int          m;
    logic [10:0] cnt;
    logic [7:0]  b0;
    bus.tx_busy = (busy_mode == 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.href  = 1'b1;
      bus.cam_d = 8'((i + seed) % 256);
      if (busy_mode == 2 && i == n / 2) bus.tx_busy = 1'b1;
      if (busy_mode != 1 && i < LINE_BYTES)
        wr_q.push_back('{at: cyc + 2, addr: 11'(HDR_BYTES + i), data: 8'((i + seed) % 256)});
    end
    @(negedge clk);
    bus.href = 1'b0;
    m = cyc;
    if (busy_mode == 1) begin
      if (exp_drop != 8'hFF) exp_drop++;
    end else begin
      cnt = (n < LINE_BYTES) ? 11'(n) : 11'(LINE_BYTES);
      b0  = {4'b0000, (n < LINE_BYTES), (n > LINE_BYTES), exp_line[9:8]};
      wr_q.push_back('{at: m + 2, addr: 11'd0, data: b0});
      wr_q.push_back('{at: m + 3, addr: 11'd1, data: exp_line[7:0]});
      wr_q.push_back('{at: m + 4, addr: 11'd2, data: exp_frame});
      wr_q.push_back('{at: m + 5, addr: 11'd3, data: cnt[7:0]});
      st_q.push_back('{at: m + 6, lnum: exp_line});
    end
    exp_line++;
    repeat (5) @(negedge clk);
  endtask

  task automatic drain(input string name);
    repeat (10) @(negedge clk);
    checks++;
    if (wr_q.size() != 0 || st_q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending: %0d writes and %0d starts outstanding, required 0 and 0",
               name, wr_q.size(), st_q.size());
    end
    wr_q.delete();
    st_q.delete();
    $display("%s done at cycle %0d", name, cyc);
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if ({bus.wr_en, bus.addr, bus.din, bus.start} !== 21'd0) begin
      errors++;
      $display("FAIL %s_ram_port: wr_en=%b addr=%0d din=0x%02h start=%b, required all 0",
               name, bus.wr_en, bus.addr, bus.din, bus.start);
    end
    checks++;
    if (bus.line_num !== 10'd0 || bus.drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL %s_counters: line_num=%0d drop_cnt=%0d, required 0 and 0",
               name, bus.line_num, bus.drop_cnt);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    $display("test_reset done at cycle %0d", cyc);
  endtask

  task automatic test_basic_frame();
    start_frame();
    drive_line(LINE_BYTES, 0, 0);
    drive_line(LINE_BYTES, 0, 0);
    drain("test_basic_frame");
  endtask

  task automatic test_drop();
    start_frame();
    drive_line(16, 0, 3);
    drive_line(16, 1, 0);
    checks++;
    if (bus.drop_cnt !== exp_drop) begin
      errors++;
      $display("FAIL drop_count: drop_cnt=%0d, required %0d", bus.drop_cnt, exp_drop);
    end
    drive_line(16, 0, 5);
    drive_line(40, 2, 11);
    drain("test_drop");
  endtask

  task automatic test_short_long();
    drive_line(100, 0, 7);
    max_addr = 0;
    drive_line(1300, 0, 9);
    drain("test_short_long");
    checks++;
    if (max_addr > LINE_BYTES + HDR_BYTES - 1) begin
      errors++;
      $display("FAIL long_line_addr: highest addr written=%0d, required <= %0d",
               max_addr, LINE_BYTES + HDR_BYTES - 1);
    end
  endtask

  task automatic test_vsync_abort();
    start_frame();
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      bus.href  = 1'b1;
      bus.cam_d = 8'((i * 3) % 256);
      wr_q.push_back('{at: cyc + 2, addr: 11'(HDR_BYTES + i), data: 8'((i * 3) % 256)});
    end
    @(negedge clk);
    bus.href  = 1'b0;
    bus.vsync = 1'b1;
    repeat (3) @(negedge clk);
    bus.vsync = 1'b0;
    exp_frame++;
    exp_line = '0;
    repeat (3) @(negedge clk);
    drive_line(8, 0, 1);
    drain("test_vsync_abort");
  endtask

  task automatic test_reset_mid_capture();
    start_frame();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      bus.href  = 1'b1;
      bus.cam_d = 8'(i);
      wr_q.push_back('{at: cyc + 2, addr: 11'(HDR_BYTES + i), data: 8'(i)});
    end
    @(negedge clk);
    bus.cam_d = 8'd50;
    #1 rst_n = 1'b0;
    wr_q.delete();
    #1 check_reset_outputs("reset_mid");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_line  = '0;
    exp_frame = '0;
    exp_drop  = '0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      bus.href  = 1'b1;
      bus.cam_d = 8'(i + 51);
    end
    @(negedge clk);
    bus.href = 1'b0;
    drain("test_reset_mid_ignore");
    start_frame();
    drive_line(10, 0, 2);
    drain("test_reset_mid_recover");
  endtask

  task automatic test_drop_saturate();
    start_frame();
    for (int i = 0; i < 300; i++) begin
      drive_line(4, 1, 0);
      if (i == 0 || i == 254 || i == 299) begin
        checks++;
        if (bus.drop_cnt !== exp_drop) begin
          errors++;
          $display("FAIL drop_saturate_%0d: drop_cnt=%0d, required %0d", i, bus.drop_cnt, exp_drop);
        end
      end
    end
    drive_line(4, 0, 0);
    drain("test_drop_saturate");
  endtask

  task automatic test_line_wrap();
    start_frame();
    for (int i = 0; i < 1030; i++) drive_line(2, 0, i);
    drain("test_line_wrap");
  endtask

  initial begin
    bus.vsync   = 1'b0;
    bus.href    = 1'b0;
    bus.cam_d   = 8'd0;
    bus.tx_busy = 1'b0;
    fork
      monitor();
    join_none
    test_reset();
    test_basic_frame();
    test_drop();
    test_short_long();
    test_vsync_abort();
    test_reset_mid_capture();
    test_drop_saturate();
    test_line_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
